ysyx_23060236_axi_sram: RTL

YSYX_23060236_AXI_SRAM -- requirements
Module: ysyx_23060236_axi_sram

---
 rtl/ysyx_23060236_axi_sram_if.sv | 66 ++++++
 rtl/ysyx_23060236_axi_sram.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060236_axi_sram_if.sv
// rtl/ysyx_23060236_axi_sram_if.sv - AXI4 channel bundle for the SRAM slave
// Purpose: groups the AR/R/AW/W/B channels of one 32-bit AXI4 link.
// Modports: master drives AR/AW/W payloads plus rready/bready;
//           slave drives arready/awready/wready plus the R and B payloads.

interface ysyx_23060236_axi_sram_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp, bid,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp, bid,
    input  bready
  );
endinterface

// File: rtl/ysyx_23060236_axi_sram.sv
// rtl/ysyx_23060236_axi_sram.sv - AXI4 slave SRAM with fixed read latency and single-beat writes
// Purpose: 2^DEPTH_LOG2 x 32-bit word array at ADDR_BASE. Reads are INCR/FIXED
//          bursts of up to 16 beats, first beat RD_LAT cycles after AR; writes
//          are single beats with byte strobes. Out-of-range accesses get SLVERR.
// Ports:   clock - single clock
//          reset - asynchronous active-low reset
//          bus   - slave side of the AR/R/AW/W/B channel bundle

module ysyx_23060236_axi_sram #(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter int          RD_LAT     = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  ysyx_23060236_axi_sram_if.slave bus
);
  localparam int          DEPTH = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN  = 33'(DEPTH) << 2;

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  // Array contents survive reset on purpose.
  logic [31:0] mem [DEPTH];

  // Borrow out of the 33-bit subtraction flags addresses below the base.
  function automatic logic in_range(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, ADDR_BASE};
    return !off[32] && (off < SPAN);
  endfunction

  function automatic idx_t word_idx(input logic [31:0] a);
    return idx_t'((a - ADDR_BASE) >> 2);
  endfunction

  // ---------------- read channel ----------------
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  r_state_t r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_len;
  logic [3:0] r_beat;
  idx_t       r_idx;
  logic       r_fixed;
  logic       r_err;
  idx_t       r_next_idx;

  assign r_next_idx = r_fixed ? r_idx : r_idx + idx_t'(1);

  // rdata is sampled from the array on the edge a beat becomes valid, so a
  // write committing on that same edge is not observed by that beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= R_IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_beat      <= '0;
      r_idx       <= '0;
      r_fixed     <= 1'b0;
      r_err       <= 1'b0;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rdata   <= '0;
      bus.rresp   <= '0;
      bus.rlast   <= 1'b0;
      bus.rid     <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          bus.arready <= 1'b1;
          if (bus.arvalid && bus.arready) begin
            bus.arready <= 1'b0;
            r_state     <= R_WAIT;
            r_cnt       <= 4'(RD_LAT - 1);
            r_len       <= bus.arlen[3:0];
            r_fixed     <= (bus.arburst == 2'b00);
            r_err       <= !in_range(bus.araddr);
            r_idx       <= word_idx(bus.araddr);
            r_beat      <= '0;
            bus.rid     <= bus.arid;
          end
        end
        R_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state    <= R_DATA;
            bus.rvalid <= 1'b1;
            bus.rdata  <= r_err ? 32'd0 : mem[r_idx];
            bus.rresp  <= r_err ? 2'b10 : 2'b00;
            bus.rlast  <= (r_len == 4'd0);
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        R_DATA: begin
          if (bus.rready) begin
            if (bus.rlast) begin
              r_state     <= R_IDLE;
              bus.rvalid  <= 1'b0;
              bus.rlast   <= 1'b0;
              bus.arready <= 1'b1;
            end else begin
              r_beat    <= r_beat + 4'd1;
              r_idx     <= r_next_idx;
              bus.rdata <= r_err ? 32'd0 : mem[r_next_idx];
              bus.rlast <= (4'(r_beat + 4'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- write channel ----------------
  typedef enum logic [1:0] {W_IDLE, W_AW, W_W, W_RESP} w_state_t;

  w_state_t w_state;
  logic [31:0] w_addr;
  logic [7:0]  w_len;
  logic [3:0]  w_id;
  logic [31:0] w_data;
  logic [3:0]  w_strb;

  logic        aw_fire;
  logic        w_fire;
  logic        commit;
  logic        c_err;
  logic [31:0] c_addr;
  logic [31:0] c_data;
  logic [7:0]  c_len;
  logic [3:0]  c_strb;

  // The completing handshake supplies its half live from the bus; the other
  // half comes from whatever was latched earlier.
  always_comb begin
    aw_fire = bus.awvalid && bus.awready;
    w_fire  = bus.wvalid && bus.wready;
    commit  = ((w_state == W_IDLE) && aw_fire && w_fire) ||
              ((w_state == W_AW) && w_fire) ||
              ((w_state == W_W) && aw_fire);
    c_addr  = aw_fire ? bus.awaddr : w_addr;
    c_len   = aw_fire ? bus.awlen  : w_len;
    c_data  = w_fire  ? bus.wdata  : w_data;
    c_strb  = w_fire  ? bus.wstrb  : w_strb;
    c_err   = !in_range(c_addr) || (c_len != 8'd0);
  end

  always_ff @(posedge clock) begin
    if (commit && !c_err) begin
      for (int b = 0; b < 4; b++) begin
        if (c_strb[b]) mem[word_idx(c_addr)][8*b +: 8] <= c_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_state     <= W_IDLE;
      w_addr      <= '0;
      w_len       <= '0;
      w_id        <= '0;
      w_data      <= '0;
      w_strb      <= '0;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bresp   <= '0;
      bus.bid     <= '0;
    end else begin
      if (aw_fire) begin
        w_addr <= bus.awaddr;
        w_len  <= bus.awlen;
        w_id   <= bus.awid;
      end
      if (w_fire) begin
        w_data <= bus.wdata;
        w_strb <= bus.wstrb;
      end
      case (w_state)
        W_IDLE: begin
          bus.awready <= 1'b1;
          bus.wready  <= 1'b1;
          if (aw_fire && !w_fire) begin
            w_state     <= W_AW;
            bus.awready <= 1'b0;
          end else if (w_fire && !aw_fire) begin
            w_state    <= W_W;
            bus.wready <= 1'b0;
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            w_state     <= W_IDLE;
            bus.bvalid  <= 1'b0;
            bus.awready <= 1'b1;
            bus.wready  <= 1'b1;
          end
        end
        default: ;
      endcase
      if (commit) begin
        w_state     <= W_RESP;
        bus.awready <= 1'b0;
        bus.wready  <= 1'b0;
        bus.bvalid  <= 1'b1;
        bus.bresp   <= c_err ? 2'b10 : 2'b00;
        bus.bid     <= aw_fire ? bus.awid : w_id;
      end
    end
  end

  // Accepted for protocol completeness but not needed by a word-wide array.
  logic unused_ok;
  assign unused_ok = &{1'b0, bus.arsize, bus.awsize, bus.awburst, bus.wlast, bus.arlen[7:4]};
endmodule
